tcdm_burst_master: RTL and testbench

// eFPGA-side TCDM request generator, one stage upstream of the eFPGA/SoC TCDM clock-crossing bridge.

---
 rtl/tcdm_burst_master.sv | 179 +++++++++++++++++
 tb/tb_tcdm_burst_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_burst_master.sv
// tcdm_burst_master: turns one burst command into sequential single-word TCDM
// requests toward the eFPGA/SoC clock-crossing bridge, streaming write data in
// and read data out, while capping in-flight requests below the bridge's
// response FIFO depth.
//
// Ports:
//   efpga_clk, efpga_rst_n      clock, synchronous active-low reset
//   cmd_valid/ready/addr/len/write   burst command handshake
//   wr_valid/ready/data         write-data stream (wr_ready is combinational)
//   rd_valid/rd_data            read-data stream, no backpressure
//   busy, done, err             status (err is sticky until next command)
//   efpga_req/gnt/req_data      registered request toward the bridge
//   efpga_valid/rdata           in-order responses from the bridge
module tcdm_burst_master #(
    parameter int unsigned LEN_W           = 12,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic             efpga_clk,
    input  logic             efpga_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [19:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_write,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             efpga_req,
    input  logic             efpga_gnt,
    output logic [56:0]      efpga_req_data,
    input  logic             efpga_valid,
    input  logic [31:0]      efpga_rdata
);

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Request payload as seen by the bridge: {addr, be, wdata, wen}
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [DATA_W-1:0] wdata;
        logic              wen;
    } req_t;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              dir_write;
    logic [OUT_W-1:0]  outstanding;
    req_t              req_q;

    logic              cmd_accept;
    logic              load;
    logic              done_nxt;
    logic              req_accept;
    logic              rsp_ok;
    logic              rsp_stray;

    // State register
    always_ff @(posedge efpga_clk) begin
        if (!efpga_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt  = state;
        cmd_accept = 1'b0;
        load       = 1'b0;
        done_nxt   = 1'b0;
        req_accept = efpga_req & efpga_gnt;
        rsp_ok     = efpga_valid & (outstanding != '0);
        rsp_stray  = efpga_valid & (outstanding == '0);
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_accept = 1'b1;
                    state_nxt  = (cmd_len == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Request slot free, response budget left, and data on hand for writes
                load = (remaining != '0) & (!efpga_req | efpga_gnt)
                     & (outstanding < OUT_W'(MAX_OUTSTANDING))
                     & (!dir_write | wr_valid);
                if (load && (remaining == LEN_W'(1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((outstanding == '0) && !efpga_req) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake readies are combinational; masked while reset is held so the
    // reset cycle itself shows them low.
    assign cmd_ready = efpga_rst_n & (state == S_IDLE);
    assign wr_ready  = efpga_rst_n & load & dir_write;

    assign efpga_req_data = req_q;

    // Datapath, request register, counters and status
    always_ff @(posedge efpga_clk) begin
        if (!efpga_rst_n) begin
            cur_addr    <= '0;
            remaining   <= '0;
            dir_write   <= 1'b0;
            outstanding <= '0;
            efpga_req   <= 1'b0;
            req_q       <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (cmd_accept) begin
                cur_addr  <= cmd_addr & ~ADDR_W'(3);
                remaining <= cmd_len;
                dir_write <= cmd_write;
            end else if (load) begin
                cur_addr  <= cur_addr + ADDR_W'(4);
                remaining <= remaining - LEN_W'(1);
            end

            if (load) begin
                efpga_req   <= 1'b1;
                req_q.addr  <= cur_addr;
                req_q.be    <= 4'hF;
                req_q.wdata <= dir_write ? wr_data : '0;
                req_q.wen   <= !dir_write;
            end else if (req_accept) begin
                efpga_req <= 1'b0;
            end

            // Counted from load, so un-granted requests already hold a response slot
            case ({load, rsp_ok})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            rd_valid <= rsp_ok & !dir_write;
            if (rsp_ok && !dir_write) begin
                rd_data <= efpga_rdata;
            end

            busy <= (state_nxt != S_IDLE);
            done <= done_nxt;

            if (rsp_stray) begin
                err <= 1'b1;
            end else if (cmd_accept) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tcdm_burst_master.sv
module tb_tcdm_burst_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] cmd_addr;
    logic [11:0] cmd_len;
    logic        cmd_write;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        efpga_req;
    logic        gnt;
    logic [56:0] efpga_req_data;
    logic        efpga_valid;
    logic [31:0] efpga_rdata;

    logic        man_valid;
    logic [31:0] man_rdata;
    logic        auto_en;
    logic [1:0]  pv = '0;
    logic [19:0] pa0 = '0;
    logic [19:0] pa1 = '0;

    int n_tot  = 0;
    int n_pass = 0;
    int nacc, nrd, nrsp, ndone;

    tcdm_burst_master dut (
        .efpga_clk     (clk),
        .efpga_rst_n   (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_write     (cmd_write),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .efpga_req     (efpga_req),
        .efpga_gnt     (gnt),
        .efpga_req_data(efpga_req_data),
        .efpga_valid   (efpga_valid),
        .efpga_rdata   (efpga_rdata)
    );

    always #5 clk = ~clk;

    // Auto responder: answers each accepted request 2 cycles later with {B00, addr}
    always @(posedge clk) begin
        pv  <= {pv[0], auto_en & efpga_req & gnt};
        pa0 <= efpga_req_data[56:37];
        pa1 <= pa0;
    end
    assign efpga_valid = man_valid | pv[1];
    assign efpga_rdata = pv[1] ? {12'hB00, pa1} : man_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [56:0] mk(input logic [19:0] a, input logic [31:0] d, input logic wen);
        return {a, 4'hF, d, wen};
    endfunction

    function automatic logic [19:0] ea(input logic [19:0] a, input int k);
        logic [19:0] b;
        b = a & 20'hFFFFC;
        return 20'(b + 20'(k * 4));
    endfunction

    function automatic logic [31:0] wword(input int i);
        return 32'h5A00_0000 + 32'(i * 32'h0101);
    endfunction

    task automatic sample();
        #1;
        if (efpga_req && gnt) nacc++;
        if (rd_valid) nrd++;
        if (efpga_valid) nrsp++;
        if (done) ndone++;
    endtask

    typedef struct {
        logic        cv;
        logic [19:0] ca;
        logic [11:0] cl;
        logic        cw;
        logic        rv;
        logic [31:0] rdi;
        logic        e_cr, e_wr, e_rv;
        logic [31:0] e_rd;
        logic        e_busy, e_done, e_err, e_req;
        logic [56:0] e_rq;
    } vec_t;

    function automatic vec_t V(input logic cv, input logic [19:0] ca, input logic [11:0] cl,
                               input logic cw, input logic rv, input logic [31:0] rdi,
                               input logic cr, input logic wr, input logic rvo,
                               input logic [31:0] rdo, input logic bsy, input logic dn,
                               input logic er, input logic rq, input logic [56:0] rqd);
        vec_t t;
        t.cv = cv; t.ca = ca; t.cl = cl; t.cw = cw; t.rv = rv; t.rdi = rdi;
        t.e_cr = cr; t.e_wr = wr; t.e_rv = rvo; t.e_rd = rdo; t.e_busy = bsy;
        t.e_done = dn; t.e_err = er; t.e_req = rq; t.e_rq = rqd;
        return t;
    endfunction

    // Generic burst with auto responses; optional wr_valid toggle and gnt-low window
    task automatic burst(input string nm, input logic [19:0] a, input int len, input logic w,
                         input bit toggle, input int glo, input int ghi);
        logic [4:0] pat;
        int wi;
        int nwr;
        pat = 5'b11101;
        wi = 0; nwr = 0; nacc = 0; nrd = 0; nrsp = 0; ndone = 0;
        auto_en = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = 12'(len); cmd_write = w; gnt = 1'b1;
        #1;
        chk({nm, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        for (int c = 1; c < 80 && ndone == 0; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            gnt = !(c >= glo && c < ghi);
            wr_valid = (toggle && c <= 5) ? pat[c-1] : 1'b1;
            wr_data = wword(wi);
            #1;
            if (!gnt) begin
                chk($sformatf("%s.hold_req%0d", nm, c), 64'(efpga_req), 64'd1);
                chk($sformatf("%s.hold_data%0d", nm, c), 64'(efpga_req_data),
                    64'(mk(ea(a, nacc), w ? wword(nacc) : 32'h0, !w)));
                chk($sformatf("%s.hold_wrr%0d", nm, c), 64'(wr_ready), 64'd0);
            end
            if (wr_ready) begin
                chk($sformatf("%s.wrr_valid%0d", nm, c), 64'(wr_valid), 64'd1);
                nwr++; wi++;
            end
            if (efpga_req && gnt) begin
                chk($sformatf("%s.req%0d", nm, nacc), 64'(efpga_req_data),
                    64'(mk(ea(a, nacc), w ? wword(nacc) : 32'h0, !w)));
                nacc++;
            end
            if (efpga_valid) nrsp++;
            if (rd_valid) begin
                chk($sformatf("%s.rd%0d", nm, nrd), 64'(rd_data), 64'({12'hB00, ea(a, nrd)}));
                nrd++;
            end
            if (done) begin
                ndone++;
                chk({nm, ".done_after_rsp"}, 64'(nrsp), 64'(len));
            end
        end
        wr_valid = 1'b0; gnt = 1'b1; auto_en = 1'b0;
        chk({nm, ".n_req"}, 64'(nacc), 64'(len));
        chk({nm, ".n_wr"}, 64'(nwr), w ? 64'(len) : 64'd0);
        chk({nm, ".n_rd"}, 64'(nrd), w ? 64'd0 : 64'(len));
        chk({nm, ".n_done"}, 64'(ndone), 64'd1);
    endtask

    localparam logic [31:0] D0 = 32'hCAFE_0001;
    localparam logic [31:0] D1 = 32'hCAFE_0002;
    localparam logic [31:0] D2 = 32'hCAFE_0003;

    vec_t tbl[18];

    initial begin
        logic [56:0] r100, r104, r108;
        int sent;
        r100 = mk(20'h00100, 32'h0, 1'b1);
        r104 = mk(20'h00104, 32'h0, 1'b1);
        r108 = mk(20'h00108, 32'h0, 1'b1);

        // Read burst 0x100 x3, then len=0 read, stray response, len=0 write clearing err
        tbl[0]  = V(1, 20'h00100, 3, 0, 0, 0,    1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = V(0, 0, 0, 0,       0, 0,      0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[2]  = V(0, 0, 0, 0,       0, 0,      0, 0, 0, 0,  1, 0, 0, 1, r100);
        tbl[3]  = V(0, 0, 0, 0,       0, 0,      0, 0, 0, 0,  1, 0, 0, 1, r104);
        tbl[4]  = V(0, 0, 0, 0,       1, D0,     0, 0, 0, 0,  1, 0, 0, 1, r108);
        tbl[5]  = V(0, 0, 0, 0,       1, D1,     0, 0, 1, D0, 1, 0, 0, 0, r108);
        tbl[6]  = V(0, 0, 0, 0,       1, D2,     0, 0, 1, D1, 1, 0, 0, 0, r108);
        tbl[7]  = V(0, 0, 0, 0,       0, 0,      0, 0, 1, D2, 1, 0, 0, 0, r108);
        tbl[8]  = V(0, 0, 0, 0,       0, 0,      1, 0, 0, D2, 0, 1, 0, 0, r108);
        tbl[9]  = V(0, 0, 0, 0,       0, 0,      1, 0, 0, D2, 0, 0, 0, 0, r108);
        tbl[10] = V(1, 20'h00200, 0, 0, 0, 0,    1, 0, 0, D2, 0, 0, 0, 0, r108);
        tbl[11] = V(0, 0, 0, 0,       0, 0,      0, 0, 0, D2, 1, 0, 0, 0, r108);
        tbl[12] = V(0, 0, 0, 0,       0, 0,      1, 0, 0, D2, 0, 1, 0, 0, r108);
        tbl[13] = V(0, 0, 0, 0,       1, 32'hDEAD, 1, 0, 0, D2, 0, 0, 0, 0, r108);
        tbl[14] = V(0, 0, 0, 0,       0, 0,      1, 0, 0, D2, 0, 0, 1, 0, r108);
        tbl[15] = V(1, 20'h00300, 0, 1, 0, 0,    1, 0, 0, D2, 0, 0, 1, 0, r108);
        tbl[16] = V(0, 0, 0, 0,       0, 0,      0, 0, 0, D2, 1, 0, 0, 0, r108);
        tbl[17] = V(0, 0, 0, 0,       0, 0,      1, 0, 0, D2, 0, 1, 0, 0, r108);

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_write = 1'b0;
        wr_valid = 1'b0; wr_data = '0; gnt = 1'b1; man_valid = 1'b0; man_rdata = '0;
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.req", 64'(efpga_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            cmd_valid = tbl[i].cv; cmd_addr = tbl[i].ca; cmd_len = tbl[i].cl;
            cmd_write = tbl[i].cw; man_valid = tbl[i].rv; man_rdata = tbl[i].rdi;
            #1;
            chk($sformatf("v%0d.cmd_ready", i), 64'(cmd_ready), 64'(tbl[i].e_cr));
            chk($sformatf("v%0d.wr_ready", i), 64'(wr_ready), 64'(tbl[i].e_wr));
            chk($sformatf("v%0d.rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rv));
            chk($sformatf("v%0d.rd_data", i), 64'(rd_data), 64'(tbl[i].e_rd));
            chk($sformatf("v%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("v%0d.done", i), 64'(done), 64'(tbl[i].e_done));
            chk($sformatf("v%0d.err", i), 64'(err), 64'(tbl[i].e_err));
            chk($sformatf("v%0d.req", i), 64'(efpga_req), 64'(tbl[i].e_req));
            chk($sformatf("v%0d.req_data", i), 64'(efpga_req_data), 64'(tbl[i].e_rq));
        end
        @(negedge clk);
        cmd_valid = 1'b0; man_valid = 1'b0;

        burst("wr",   20'h00200, 4, 1'b1, 1'b1, 0, 0);
        burst("bp",   20'h00403, 4, 1'b1, 1'b0, 3, 8);
        burst("wrap", 20'hFFFFC, 2, 1'b0, 1'b0, 0, 0);

        // Outstanding cap: 8-word read, responses withheld
        nacc = 0; nrd = 0; nrsp = 0; ndone = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 20'h00800; cmd_len = 12'd8; cmd_write = 1'b0; gnt = 1'b1;
        #1;
        repeat (10) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            sample();
        end
        chk("cap.issued4", 64'(nacc), 64'd4);
        chk("cap.stalled", 64'(efpga_req), 64'd0);
        @(negedge clk);
        man_valid = 1'b1; man_rdata = 32'h11;
        sample();
        @(negedge clk);
        man_rdata = 32'h22;
        sample();
        chk("cap.rd1_valid", 64'(rd_valid), 64'd1);
        chk("cap.rd1_data", 64'(rd_data), 64'h11);
        @(negedge clk);
        man_valid = 1'b0;
        sample();
        chk("cap.rd2_data", 64'(rd_data), 64'h22);
        repeat (8) begin
            @(negedge clk);
            sample();
        end
        chk("cap.inc_dec_same", 64'(nacc), 64'd6);
        sent = 2;
        for (int c = 0; c < 60 && ndone == 0; c++) begin
            @(negedge clk);
            man_valid = (sent < nacc);
            man_rdata = 32'hC000_0000 + 32'(sent);
            if (man_valid) sent++;
            sample();
        end
        man_valid = 1'b0;
        chk("cap.total_req", 64'(nacc), 64'd8);
        chk("cap.total_rd", 64'(nrd), 64'd8);
        chk("cap.done", 64'(ndone), 64'd1);

        // Reset in the middle of a write burst
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 20'h00040; cmd_len = 12'd4; cmd_write = 1'b1;
        wr_valid = 1'b1; wr_data = 32'h7777_0000;
        repeat (2) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst.busy_before", 64'(busy), 64'd1);
        chk("mrst.cmd_ready_in", 64'(cmd_ready), 64'd0);
        chk("mrst.wr_ready_in", 64'(wr_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; wr_valid = 1'b0;
        #1;
        chk("mrst.cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mrst.wr_ready", 64'(wr_ready), 64'd0);
        chk("mrst.rd_valid", 64'(rd_valid), 64'd0);
        chk("mrst.rd_data", 64'(rd_data), 64'd0);
        chk("mrst.busy", 64'(busy), 64'd0);
        chk("mrst.done", 64'(done), 64'd0);
        chk("mrst.err", 64'(err), 64'd0);
        chk("mrst.req", 64'(efpga_req), 64'd0);
        chk("mrst.req_data", 64'(efpga_req_data), 64'd0);
        @(negedge clk);
        man_valid = 1'b1; man_rdata = 32'h9999;
        #1;
        @(negedge clk);
        man_valid = 1'b0;
        #1;
        chk("mrst.late_err", 64'(err), 64'd1);
        chk("mrst.late_rd", 64'(rd_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
